// File: rtl/aes_pkg.sv
// Shared AES constants, word type and small word helpers used by the key-schedule blocks.
package aes_pkg;

   localparam int NR = 14;
   localparam int NK = 8;

   typedef logic [31:0] word_t;

   // Out-of-range indices (including 0) collapse to zero so no lookup runs off the table.
   function automatic logic [7:0] rcon(input logic [3:0] idx);
      logic [7:0] v;
      case (idx)
         4'd1:    v = 8'h01;
         4'd2:    v = 8'h02;
         4'd3:    v = 8'h04;
         4'd4:    v = 8'h08;
         4'd5:    v = 8'h10;
         4'd6:    v = 8'h20;
         4'd7:    v = 8'h40;
         default: v = 8'h00;
      endcase
      return v;
   endfunction

   function automatic word_t rot_word(input word_t x);
      return {x[23:0], x[31:24]};
   endfunction

endpackage

// File: rtl/aes_sbox.sv
// Forward AES S-box, one byte, purely combinational table lookup.
module aes_sbox (
   input  logic [7:0] a,
   output logic [7:0] y
);

   localparam logic [7:0] SBOX [0:255] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   assign y = SBOX[a];

endmodule

// File: rtl/aes_subword.sv
// SubWord: four parallel S-box lookups on one 32-bit word.
module aes_subword
   import aes_pkg::*;
(
   input  word_t x,
   output word_t y
);

   for (genvar g = 0; g < 4; g++) begin : g_byte
      aes_sbox u_sbox (
         .a (x[8*g +: 8]),
         .y (y[8*g +: 8])
      );
   end

endmodule

// File: rtl/aes_inv_keyexpansion_256.sv
// Reverse-order AES-256 key schedule: emits rk14..rk0 from {rk13, rk14} using a two-key window.
module aes_inv_keyexpansion_256
   import aes_pkg::*;
(
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic [255:0] last_key,
   output logic [127:0] subkey,
   output logic         subkey_valid,
   input  logic         subkey_ready,
   output logic [3:0]   round_idx,
   output logic         busy,
   output logic         done
);

   logic [127:0] hi, lo;
   logic [3:0]   r;
   logic         busy_q, done_q;

   word_t a0, a1, a2, a3, h3;
   word_t sw_in, sw_out, t;
   logic [127:0] nxt;

   assign a0 = lo[127:96];
   assign a1 = lo[95:64];
   assign a2 = lo[63:32];
   assign a3 = lo[31:0];
   assign h3 = hi[31:0];

   // Even rounds sit on an 8-word boundary of the forward schedule and need RotWord + Rcon.
   assign sw_in = r[0] ? h3 : rot_word(h3);

   aes_subword u_subword (
      .x (sw_in),
      .y (sw_out)
   );

   assign t   = r[0] ? sw_out : (sw_out ^ {rcon({1'b0, r[3:1]}), 24'h0});
   assign nxt = {a0 ^ t, a1 ^ a0, a2 ^ a1, a3 ^ a2};

   always_ff @(posedge clk) begin
      if (reset) begin
         hi     <= '0;
         lo     <= '0;
         r      <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (!busy_q) begin
            if (start) begin
               hi     <= last_key[255:128];
               lo     <= last_key[127:0];
               r      <= 4'(NR);
               busy_q <= 1'b1;
            end
         end else if (subkey_ready) begin
            if (r != 4'd0) begin
               lo <= hi;
               hi <= nxt;
               r  <= r - 4'd1;
            end else begin
               busy_q <= 1'b0;
               done_q <= 1'b1;
            end
         end
      end
   end

   assign subkey       = lo;
   assign subkey_valid = busy_q;
   assign round_idx    = r;
   assign busy         = busy_q;
   assign done         = done_q;

endmodule
